// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory arbiter
//
// Purpose: the arbiter FSM state encoding and the owner identifiers shared by
// dmem_arbiter and rr_arb2.
// Ports: none (package).

package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DMA = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin winner selection
//
// Purpose: picks which requester is granted when the arbiter is idle.
// Ports:
//   i_cpu_req     in   CPU request level
//   i_dma_req     in   DMA request level
//   i_last_owner  in   owner of the most recent grant
//   o_winner      out  granted owner (OWNER_CPU / OWNER_DMA); only
//                      meaningful when at least one request is high

module rr_arb2
    import dmem_pkg::*;
(
    input  logic i_cpu_req,
    input  logic i_dma_req,
    input  logic i_last_owner,
    output logic o_winner
);

    always_comb begin
        o_winner = OWNER_CPU;
        if (i_cpu_req && i_dma_req) begin
            // Tie: whoever was not served last goes next.
            o_winner = (i_last_owner == OWNER_CPU) ? OWNER_DMA : OWNER_CPU;
        end else if (i_dma_req) begin
            o_winner = OWNER_DMA;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/DMA arbiter in front of a single-port data memory
//
// Purpose: grants one of two level requesters, performs one memory access,
// and returns a one-cycle ack with read data / error. Fixed latency: request
// sampled in IDLE cycle c, memory strobe in c+1, ack in c+2.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   cpu_req/we/addr/wdata           CPU request side (level, held until ack)
//   cpu_ack/rdata/err               CPU completion (valid in ack cycle)
//   dma_req/we/addr/wdata           DMA request side
//   dma_ack/rdata/err               DMA completion
//   mem_read, mem_write             memory strobes (only in ACCESS, legal)
//   mem_address, mem_write_data     memory address / write data (0 outside ACCESS)
//   mem_read_data                   combinational memory read data
//   busy                            high while a transaction is in flight

module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_ack,
    output logic [31:0] dma_rdata,
    output logic        dma_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    output logic        busy
);

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

    state_t      r_state;
    state_t      w_next_state;
    logic        r_owner;
    logic        r_last_owner;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_cpu_rdata;
    logic [31:0] r_dma_rdata;
    logic        r_cpu_err;
    logic        r_dma_err;

    logic        w_any_req;
    logic        w_winner;
    logic        w_legal;
    logic        w_in_access;
    logic        w_in_done;

    assign w_any_req = cpu_req | dma_req;

    rr_arb2 u_rr_arb2 (
        .i_cpu_req    (cpu_req),
        .i_dma_req    (dma_req),
        .i_last_owner (r_last_owner),
        .o_winner     (w_winner)
    );

    assign w_legal = (r_addr[1:0] == 2'b00) && (r_addr < MEM_LIMIT);

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_next_state = ACCESS;
            ACCESS:  w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Request latch and per-owner response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner      <= OWNER_CPU;
            r_last_owner <= OWNER_DMA;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cpu_rdata  <= '0;
            r_dma_rdata  <= '0;
            r_cpu_err    <= 1'b0;
            r_dma_err    <= 1'b0;
        end else begin
            if (r_state == IDLE && w_any_req) begin
                r_owner      <= w_winner;
                r_last_owner <= w_winner;
                if (w_winner == OWNER_DMA) begin
                    r_we    <= dma_we;
                    r_addr  <= dma_addr;
                    r_wdata <= dma_wdata;
                end else begin
                    r_we    <= cpu_we;
                    r_addr  <= cpu_addr;
                    r_wdata <= cpu_wdata;
                end
            end
            // Only the owner's response registers move; the other side
            // keeps whatever it returned last.
            if (r_state == ACCESS) begin
                if (r_owner == OWNER_DMA) begin
                    r_dma_rdata <= w_legal ? mem_read_data : 32'h0;
                    r_dma_err   <= ~w_legal;
                end else begin
                    r_cpu_rdata <= w_legal ? mem_read_data : 32'h0;
                    r_cpu_err   <= ~w_legal;
                end
            end
        end
    end

    // Outputs are forced quiet in any reset cycle so a reset landing in
    // ACCESS cannot commit a write and a reset in DONE cannot leak an ack.
    assign w_in_access = (r_state == ACCESS) && !reset;
    assign w_in_done   = (r_state == DONE) && !reset;

    assign mem_read       = w_in_access && w_legal && !r_we;
    assign mem_write      = w_in_access && w_legal && r_we;
    assign mem_address    = w_in_access ? r_addr  : 32'h0;
    assign mem_write_data = w_in_access ? r_wdata : 32'h0;

    assign cpu_ack   = w_in_done && (r_owner == OWNER_CPU);
    assign dma_ack   = w_in_done && (r_owner == OWNER_DMA);
    assign cpu_rdata = reset ? 32'h0 : r_cpu_rdata;
    assign dma_rdata = reset ? 32'h0 : r_dma_rdata;
    assign cpu_err   = !reset && r_cpu_err;
    assign dma_err   = !reset && r_dma_err;
    assign busy      = !reset && (r_state != IDLE);

endmodule
